// File: rtl/apb2axi.sv
// rtl/apb2axi.sv - APB3/APB4 completer bridging each access to one single-beat AXI4 transaction
module apb2axi #(
    parameter int IDWID   = 4,
    parameter int DWID    = 64,
    parameter int EXTRAS  = 8,
    parameter int AXI_ID  = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    output logic                pready,
    output logic [31:0]         prdata,
    output logic                pslverr,

    output logic [IDWID-1:0]    arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [EXTRAS-1:0]   arextras,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,

    input  logic [IDWID-1:0]    rid,
    input  logic [DWID-1:0]     rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [IDWID-1:0]    awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [EXTRAS-1:0]   awextras,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,

    output logic [DWID-1:0]     wdata,
    output logic [DWID/8-1:0]   wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [IDWID-1:0]    bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam logic [IDWID-1:0] ID_C   = IDWID'(AXI_ID);
    localparam logic [15:0]      TO_C   = 16'(TIMEOUT);
    localparam logic [31:0]      ERR_RD = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    logic        hi_q;      // selects upper 32-bit lane of the 64-bit beat
    logic [15:0] tcnt;
    logic        owe_r;     // read response still expected after a timeout
    logic        owe_b;     // write response still expected after a timeout

    logic [15:0] tcnt_nxt;
    logic        timeout_hit;
    logic        ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic        ar_left, aw_left, w_left;
    logic        aw_fin, w_fin, r_fin, b_fin;
    logic        unused_ok;

    // Single-beat, incrementing, fixed-ID transactions: these never change.
    assign arid     = ID_C;
    assign awid     = ID_C;
    assign arlen    = 8'd0;
    assign awlen    = 8'd0;
    assign arburst  = 2'b01;
    assign awburst  = 2'b01;
    assign arextras = '0;
    assign awextras = '0;
    assign wlast    = 1'b1;

    // Handshake and "still owed" terms shared by every state.
    always_comb begin
        tcnt_nxt    = tcnt + 16'd1;
        timeout_hit = (TO_C != 16'd0) && (tcnt_nxt >= TO_C);
        ar_hs       = arvalid && arready;
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        r_hs        = rready && rvalid;
        b_hs        = bready && bvalid;
        ar_left     = arvalid && !arready;
        aw_left     = awvalid && !awready;
        w_left      = wvalid && !wready;
        aw_fin      = !aw_left;
        w_fin       = !w_left;
        r_fin       = !owe_r || r_hs;
        b_fin       = !owe_b || b_hs;
    end

    // Low address bits, OKAY/EXOKAY distinction and penable carry no meaning here.
    assign unused_ok = ^{paddr[1:0], rresp[0], bresp[0], penable};

    // Bridge FSM: all APB and AXI outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hi_q    <= 1'b0;
            tcnt    <= 16'd0;
            owe_r   <= 1'b0;
            owe_b   <= 1'b0;
            araddr  <= 32'd0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awaddr  <= 32'd0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'd0;
        end else begin
            // A valid only ever drops on its own handshake, whatever the state.
            if (ar_hs) arvalid <= 1'b0;
            if (aw_hs) awvalid <= 1'b0;
            if (w_hs)  wvalid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Any psel in IDLE starts an access, including a late or
                    // malformed one whose penable is already high.
                    if (psel) begin
                        hi_q <= paddr[2];
                        tcnt <= 16'd0;
                        if (pwrite) begin
                            awaddr  <= {paddr[31:3], 3'b000};
                            wdata   <= {pwdata, pwdata};
                            wstrb   <= paddr[2] ? {pstrb, 4'h0} : {4'h0, pstrb};
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_WREQ;
                        end else begin
                            araddr  <= {paddr[31:3], 3'b000};
                            arvalid <= 1'b1;
                            state   <= S_RADDR;
                        end
                    end
                end

                S_RADDR: begin
                    if (ar_hs) begin
                        tcnt   <= tcnt_nxt;
                        rready <= 1'b1;
                        state  <= S_RDATA;
                    end else if (timeout_hit) begin
                        prdata  <= ERR_RD;
                        pslverr <= 1'b1;
                        pready  <= 1'b1;
                        owe_r   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                S_RDATA: begin
                    if (rvalid) begin
                        prdata  <= hi_q ? rdata[63:32] : rdata[31:0];
                        pslverr <= rresp[1] | (rid != ID_C) | !rlast;
                        pready  <= 1'b1;
                        rready  <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        prdata  <= ERR_RD;
                        pslverr <= 1'b1;
                        pready  <= 1'b1;
                        rready  <= 1'b0;
                        owe_r   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                S_WREQ: begin
                    // AW and W may complete in either order or together.
                    if (aw_fin && w_fin) begin
                        tcnt   <= tcnt_nxt;
                        bready <= 1'b1;
                        state  <= S_WRESP;
                    end else if (timeout_hit) begin
                        pslverr <= 1'b1;
                        pready  <= 1'b1;
                        owe_b   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                S_WRESP: begin
                    if (bvalid) begin
                        pslverr <= bresp[1] | (bid != ID_C);
                        pready  <= 1'b1;
                        bready  <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        pslverr <= 1'b1;
                        pready  <= 1'b1;
                        bready  <= 1'b0;
                        owe_b   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                S_DONE: begin
                    // One-cycle completion pulse; error flag goes with it.
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (owe_r || owe_b || ar_left || aw_left || w_left) begin
                        rready <= owe_r;
                        bready <= owe_b;
                        state  <= S_DRAIN;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    // Late responses are accepted and thrown away.
                    if (r_hs) begin
                        owe_r  <= 1'b0;
                        rready <= 1'b0;
                    end
                    if (b_hs) begin
                        owe_b  <= 1'b0;
                        bready <= 1'b0;
                    end
                    if (r_fin && b_fin && !ar_left && !aw_left && !w_left) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi.sv
// tb/tb_apb2axi.sv - directed self-checking bench for apb2axi
module tb_apb2axi;

    logic        clk, rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen, arextras, awextras;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic [63:0] rdata, wdata;
    logic        rlast, rvalid, rready;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    int checks   = 0;
    int failures = 0;

    apb2axi #(
        .IDWID(4), .DWID(64), .EXTRAS(8), .AXI_ID(0), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arextras(arextras),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awextras(awextras),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1;
        bvalid = 0; bid = 0; bresp = 0;
    endtask

    task automatic apb_setup(input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    endtask

    // Read with an immediately responsive slave; returns what APB saw at T3 and T4.
    task automatic run_read(input logic [31:0] a, input logic [63:0] d,
                            input logic [1:0] rr, input logic [3:0] ri,
                            output logic [31:0] prd, output logic rdy,
                            output logic err, output logic err_after);
        idle_inputs();
        apb_setup(1'b0, a, 32'd0, 4'd0);
        arready = 1; rvalid = 1; rdata = d; rresp = rr; rid = ri; rlast = 1;
        tick();
        penable = 1;
        tick();
        tick();
        prd = prdata; rdy = pready; err = pslverr;
        idle_inputs();
        tick();
        err_after = pslverr;
    endtask

    // Write with an immediately responsive slave; returns what APB saw at T3 and T4.
    task automatic run_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] br, input logic [3:0] bi,
                             output logic rdy, output logic err,
                             output logic err_after);
        idle_inputs();
        apb_setup(1'b1, a, d, 4'hF);
        awready = 1; wready = 1; bvalid = 1; bresp = br; bid = bi;
        tick();
        penable = 1;
        tick();
        tick();
        rdy = pready; err = pslverr;
        idle_inputs();
        tick();
        err_after = pslverr;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({pready, pslverr, arvalid, awvalid, wvalid, rready, bready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {pready, pslverr, arvalid, awvalid, wvalid, rready, bready});
        end
        checks++;
        if ({prdata, araddr, awaddr} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {prdata, araddr, awaddr});
        end
        checks++;
        if ({wdata, wstrb} !== 72'd0) begin
            failures++;
            $display("FAIL reset_wdata got=%h exp=0", {wdata, wstrb});
        end
        checks++;
        if ({wlast, arlen, awlen, arburst, awburst} !== {1'b1, 8'd0, 8'd0, 2'b01, 2'b01}) begin
            failures++;
            $display("FAIL reset_const got=%h exp=%h",
                     {wlast, arlen, awlen, arburst, awburst},
                     {1'b1, 8'd0, 8'd0, 2'b01, 2'b01});
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_read();
        idle_inputs();
        apb_setup(1'b0, 32'h0000_1004, 32'd0, 4'd0);
        arready = 1; rvalid = 1; rdata = 64'h1111_2222_3333_4444;
        tick();                                            // T1
        penable = 1;
        checks++;
        if ({arvalid, araddr, arlen, arburst, arid, pready} !== {1'b1, 32'h1000, 8'd0, 2'b01, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL read_T1 got=%h exp=%h", {arvalid, araddr, arlen, arburst, arid, pready},
                     {1'b1, 32'h1000, 8'd0, 2'b01, 4'd0, 1'b0});
        end
        tick();                                            // T2
        checks++;
        if ({arvalid, rready, pready} !== 3'b010) begin
            failures++;
            $display("FAIL read_T2 got=%b exp=010", {arvalid, rready, pready});
        end
        tick();                                            // T3
        checks++;
        if ({pready, pslverr, rready, prdata} !== {1'b1, 1'b0, 1'b0, 32'h1111_2222}) begin
            failures++;
            $display("FAIL read_T3 got=%h exp=%h", {pready, pslverr, rready, prdata},
                     {1'b1, 1'b0, 1'b0, 32'h1111_2222});
        end
        idle_inputs();
        tick();                                            // T4
        checks++;
        if ({pready, prdata} !== {1'b0, 32'h1111_2222}) begin
            failures++;
            $display("FAIL read_hold got=%h exp=%h", {pready, prdata}, {1'b0, 32'h1111_2222});
        end
    endtask

    task automatic test_read_low();
        logic [31:0] prd;
        logic rdy, err, err_after;
        run_read(32'h0000_1000, 64'h1111_2222_3333_4444, 2'b00, 4'd0, prd, rdy, err, err_after);
        checks++;
        if ({rdy, err, prd} !== {1'b1, 1'b0, 32'h3333_4444}) begin
            failures++;
            $display("FAIL read_low got=%h exp=%h", {rdy, err, prd}, {1'b1, 1'b0, 32'h3333_4444});
        end
    endtask

    task automatic test_write();
        idle_inputs();
        apb_setup(1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 4'b0011);
        awready = 1; wready = 1;
        tick();                                            // T1
        penable = 1;
        checks++;
        if ({awvalid, wvalid, wlast, awaddr, wdata, wstrb} !==
            {1'b1, 1'b1, 1'b1, 32'h2000, 64'hA5A5_0F0F_A5A5_0F0F, 8'h03}) begin
            failures++;
            $display("FAIL write_T1 got=%h exp=%h", {awvalid, wvalid, wlast, awaddr, wdata, wstrb},
                     {1'b1, 1'b1, 1'b1, 32'h2000, 64'hA5A5_0F0F_A5A5_0F0F, 8'h03});
        end
        tick();                                            // T2
        checks++;
        if ({awvalid, wvalid, bready, pready} !== 4'b0010) begin
            failures++;
            $display("FAIL write_T2 got=%b exp=0010", {awvalid, wvalid, bready, pready});
        end
        tick();                                            // T3: bvalid still withheld
        checks++;
        if ({bready, pready} !== 2'b10) begin
            failures++;
            $display("FAIL write_wait_b got=%b exp=10", {bready, pready});
        end
        bvalid = 1;
        tick();                                            // T4
        checks++;
        if ({pready, pslverr, bready} !== 3'b100) begin
            failures++;
            $display("FAIL write_done got=%b exp=100", {pready, pslverr, bready});
        end
        idle_inputs();
        tick();
        checks++;
        if (pready !== 1'b0) begin
            failures++;
            $display("FAIL write_pready_pulse got=%b exp=0", pready);
        end
    endtask

    task automatic test_write_late_aw();
        idle_inputs();
        apb_setup(1'b1, 32'h0000_3004, 32'h1234_5678, 4'b1100);
        wready = 1; bvalid = 1;
        tick();                                            // T1
        penable = 1;
        checks++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb} !==
            {1'b1, 1'b1, 32'h3000, 64'h1234_5678_1234_5678, 8'hC0}) begin
            failures++;
            $display("FAIL late_aw_T1 got=%h exp=%h", {awvalid, wvalid, awaddr, wdata, wstrb},
                     {1'b1, 1'b1, 32'h3000, 64'h1234_5678_1234_5678, 8'hC0});
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++;
            if ({awvalid, wvalid, bready} !== 3'b100) begin
                failures++;
                $display("FAIL late_aw_hold cycle=%0d got=%b exp=100", k, {awvalid, wvalid, bready});
            end
            if (k == 5) awready = 1;
        end
        tick();                                            // T6
        awready = 0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            failures++;
            $display("FAIL late_aw_wresp got=%b exp=001", {awvalid, wvalid, bready});
        end
        tick();                                            // T7
        checks++;
        if ({pready, pslverr} !== 2'b10) begin
            failures++;
            $display("FAIL late_aw_done got=%b exp=10", {pready, pslverr});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] prd;
        logic rdy, err, err_after;
        run_read(32'h0000_1008, 64'hAAAA_BBBB_CCCC_DDDD, 2'b10, 4'd0, prd, rdy, err, err_after);
        checks++;
        if ({rdy, err, err_after, prd} !== {1'b1, 1'b1, 1'b0, 32'hCCCC_DDDD}) begin
            failures++;
            $display("FAIL err_rresp got=%h exp=%h", {rdy, err, err_after, prd},
                     {1'b1, 1'b1, 1'b0, 32'hCCCC_DDDD});
        end
        run_read(32'h0000_100C, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'd1, prd, rdy, err, err_after);
        checks++;
        if ({rdy, err, err_after, prd} !== {1'b1, 1'b1, 1'b0, 32'hAAAA_BBBB}) begin
            failures++;
            $display("FAIL err_rid got=%h exp=%h", {rdy, err, err_after, prd},
                     {1'b1, 1'b1, 1'b0, 32'hAAAA_BBBB});
        end
        run_write(32'h0000_2008, 32'h0, 2'b00, 4'd1, rdy, err, err_after);
        checks++;
        if ({rdy, err, err_after} !== 3'b110) begin
            failures++;
            $display("FAIL err_bid got=%b exp=110", {rdy, err, err_after});
        end
        run_write(32'h0000_2008, 32'h0, 2'b10, 4'd0, rdy, err, err_after);
        checks++;
        if ({rdy, err, err_after} !== 3'b110) begin
            failures++;
            $display("FAIL err_bresp got=%b exp=110", {rdy, err, err_after});
        end
        run_write(32'h0000_2008, 32'h0, 2'b00, 4'd0, rdy, err, err_after);
        checks++;
        if ({rdy, err, err_after} !== 3'b100) begin
            failures++;
            $display("FAIL ok_write got=%b exp=100", {rdy, err, err_after});
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        arready = 1;
        apb_setup(1'b0, 32'h0000_4000, 32'd0, 4'd0);
        tick();                                            // T1: RADDR entered
        penable = 1;
        checks++;
        if (arvalid !== 1'b1) begin
            failures++;
            $display("FAIL to_arvalid got=%b exp=1", arvalid);
        end
        for (int k = 2; k <= 8; k++) begin
            tick();
            checks++;
            if (pready !== 1'b0) begin
                failures++;
                $display("FAIL to_early cycle=%0d got=%b exp=0", k, pready);
            end
        end
        tick();                                            // T9
        checks++;
        if ({pready, pslverr, rready, prdata} !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL to_done got=%h exp=%h", {pready, pslverr, rready, prdata},
                     {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF});
        end
        idle_inputs();
        tick();                                            // T10: DRAIN
        checks++;
        if ({rready, pready, pslverr} !== 3'b100) begin
            failures++;
            $display("FAIL to_drain got=%b exp=100", {rready, pready, pslverr});
        end
        apb_setup(1'b1, 32'h0000_5000, 32'hCAFE_F00D, 4'hF);
        awready = 1; wready = 1; bvalid = 1;
        for (int k = 11; k <= 20; k++) begin
            tick();
            penable = 1;
            checks++;
            if ({pready, arvalid, awvalid, rready} !== 4'b0001) begin
                failures++;
                $display("FAIL to_blocked cycle=%0d got=%b exp=0001", k,
                         {pready, arvalid, awvalid, rready});
            end
            if (k == 20) begin
                rvalid = 1;
                rdata  = 64'h9999_9999_9999_9999;
            end
        end
        tick();                                            // T21: back in IDLE
        rvalid = 0;
        checks++;
        if ({rready, awvalid, pready, prdata} !== {3'b000, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL to_absorbed got=%h exp=%h", {rready, awvalid, pready, prdata},
                     {3'b000, 32'hDEAD_BEEF});
        end
        tick();                                            // T22
        checks++;
        if ({awvalid, wvalid, awaddr, wstrb} !== {1'b1, 1'b1, 32'h5000, 8'h0F}) begin
            failures++;
            $display("FAIL to_next_req got=%h exp=%h", {awvalid, wvalid, awaddr, wstrb},
                     {1'b1, 1'b1, 32'h5000, 8'h0F});
        end
        tick();                                            // T23
        checks++;
        if ({bready, pready} !== 2'b10) begin
            failures++;
            $display("FAIL to_next_wresp got=%b exp=10", {bready, pready});
        end
        tick();                                            // T24
        checks++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL to_next_done got=%h exp=%h", {pready, pslverr, prdata},
                     {1'b1, 1'b0, 32'hDEAD_BEEF});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] prd;
        logic rdy, err, err_after;
        idle_inputs();
        apb_setup(1'b1, 32'h0000_6000, 32'h1, 4'h1);
        tick();                                            // T1
        penable = 1;
        tick();                                            // T2: stuck in WREQ
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_pre got=%b exp=11", {awvalid, wvalid});
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({awvalid, wvalid, pready, bready, prdata} !== 36'd0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=0", {awvalid, wvalid, pready, bready, prdata});
        end
        tick();
        tick();
        idle_inputs();
        rst_n = 1;
        tick();
        run_read(32'h0000_7004, 64'h0BAD_F00D_1234_5678, 2'b00, 4'd0, prd, rdy, err, err_after);
        checks++;
        if ({rdy, err, prd} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL rst_mid_recover got=%h exp=%h", {rdy, err, prd},
                     {1'b1, 1'b0, 32'h0BAD_F00D});
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_read_low();
        test_write();
        test_write_late_aw();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
